// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite animation sequencers (player and enemies).
//   anim_state_t  : motion/animation states of a sprite
//   IMG_*         : image-index codes fed to the sprite address generator
//   FRAME_WORDS   : ROM words per animation image (index is scaled by this)
//   next_walk_img : walk-cycle successor 1 -> 2 -> 3 -> 1
// -----------------------------------------------------------------------------
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WALK  = 3'd1,
        JUMP  = 3'd2,
        DYING = 3'd3,
        DEAD  = 3'd4
    } anim_state_t;

    localparam logic [2:0] IMG_STAND     = 3'd0;
    localparam logic [2:0] IMG_WALK0     = 3'd1;
    localparam logic [2:0] IMG_WALK_LAST = 3'd3;
    localparam logic [2:0] IMG_JUMP      = 3'd4;
    localparam logic [2:0] IMG_DEATH     = 3'd5;

    localparam int FRAME_WORDS = 512;

    function automatic logic [2:0] next_walk_img(input logic [2:0] idx);
        return (idx == IMG_WALK_LAST) ? IMG_WALK0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// -----------------------------------------------------------------------------
// sprite_anim_sequencer_if
// Bundle between raster/physics logic and a sprite animation sequencer.
//   hcount_in, vcount_in      : raster position
//   moving_in, airborne_in,
//   facing_left_in            : physics levels
//   collision_in, respawn_in  : single-cycle event pulses
//   unique_image_index        : animation image select (to address generator)
//   flip_h_out, dead_out,
//   frame_tick_out            : sequencer status outputs
// master = physics/raster side, slave = sequencer.
// -----------------------------------------------------------------------------
interface sprite_anim_sequencer_if;

    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        moving_in;
    logic        airborne_in;
    logic        facing_left_in;
    logic        collision_in;
    logic        respawn_in;
    logic [2:0]  unique_image_index;
    logic        flip_h_out;
    logic        dead_out;
    logic        frame_tick_out;

    modport master (
        output hcount_in, vcount_in, moving_in, airborne_in, facing_left_in,
               collision_in, respawn_in,
        input  unique_image_index, flip_h_out, dead_out, frame_tick_out
    );

    modport slave (
        input  hcount_in, vcount_in, moving_in, airborne_in, facing_left_in,
               collision_in, respawn_in,
        output unique_image_index, flip_h_out, dead_out, frame_tick_out
    );

endinterface

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Once-per-frame tick from a raster position match.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_hcount       : raster horizontal count
//   i_vcount       : raster vertical count
//   o_tick_c       : combinational match (hcount==TICK_H && vcount==TICK_V)
//   o_tick         : o_tick_c registered, high the cycle after the match
// Consumers update their state on the edge where o_tick_c is high, which is
// the same edge that raises o_tick.
// -----------------------------------------------------------------------------
module frame_tick_gen #(
    parameter int H_W    = 11,
    parameter int V_W    = 10,
    parameter int TICK_H = 0,
    parameter int TICK_V = 240
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [H_W-1:0] i_hcount,
    input  logic [V_W-1:0] i_vcount,
    output logic           o_tick_c,
    output logic           o_tick
);

    localparam logic [H_W-1:0] L_TICK_H = H_W'(TICK_H);
    localparam logic [V_W-1:0] L_TICK_V = V_W'(TICK_V);

    logic r_tick;

    assign o_tick_c = (i_hcount == L_TICK_H) && (i_vcount == L_TICK_V);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= o_tick_c;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/sprite_anim_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_anim_sequencer
// Player sprite animation controller. Tracks motion state and produces the
// 3-bit image index for the sprite address generator, updating only at the
// once-per-frame tick in vertical blanking so the index is stable over the
// whole active scan.
//   pixel_clk_in : pixel clock (sole clock)
//   rst_n_in     : synchronous active-low reset
//   bus          : sprite_anim_sequencer_if.slave (raster, physics inputs,
//                  image index / flip / dead / frame tick outputs)
// Image codes: 0 stand, 1..3 walk phases, 4 jump, 5 death.
// -----------------------------------------------------------------------------
module sprite_anim_sequencer
    import sprite_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 6,
    parameter int DEATH_HOLD      = 30,
    parameter int TICK_H          = 0,
    parameter int TICK_V          = 240
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_n_in,
    sprite_anim_sequencer_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_WALK  = WALK;
    localparam logic [2:0] S_JUMP  = JUMP;
    localparam logic [2:0] S_DYING = DYING;
    localparam logic [2:0] S_DEAD  = DEAD;

    localparam logic [5:0] STEP_LAST  = 6'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_HOLD - 1);

    logic [2:0] r_state;
    logic [2:0] r_idx;
    logic       r_flip;
    logic       r_dead;
    logic [5:0] r_step_cnt;
    logic [7:0] r_death_cnt;
    logic       r_col_pend;
    logic       r_res_pend;

    logic       w_tick_c;
    logic       w_frame_tick;
    logic       w_col;
    logic       w_res;

    frame_tick_gen #(
        .H_W    (11),
        .V_W    (10),
        .TICK_H (TICK_H),
        .TICK_V (TICK_V)
    ) u_tick (
        .i_clk    (pixel_clk_in),
        .i_rst_n  (rst_n_in),
        .i_hcount (bus.hcount_in),
        .i_vcount (bus.vcount_in),
        .o_tick_c (w_tick_c),
        .o_tick   (w_frame_tick)
    );

    // Sticky event view at the tick: a pulse on the tick cycle itself counts.
    assign w_col = r_col_pend | bus.collision_in;
    assign w_res = r_res_pend | bus.respawn_in;

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_idx       <= IMG_STAND;
            r_flip      <= 1'b0;
            r_dead      <= 1'b0;
            r_step_cnt  <= '0;
            r_death_cnt <= '0;
            r_col_pend  <= 1'b0;
            r_res_pend  <= 1'b0;
        end else if (w_tick_c) begin
            // Pending events are consumed at every tick, whatever the state;
            // this is what discards a respawn requested while dying.
            r_col_pend <= 1'b0;
            r_res_pend <= 1'b0;
            case (r_state)
                S_DYING: begin
                    if (r_death_cnt == DEATH_LAST) begin
                        r_state <= S_DEAD;
                        r_dead  <= 1'b1;
                    end else begin
                        r_death_cnt <= r_death_cnt + 8'd1;
                    end
                end
                S_DEAD: begin
                    if (w_res) begin
                        r_state <= S_IDLE;
                        r_idx   <= IMG_STAND;
                        r_dead  <= 1'b0;
                    end
                end
                // IDLE, WALK, JUMP; unused codes also recover through here.
                default: begin
                    r_flip <= bus.facing_left_in;
                    if (w_col) begin
                        r_state     <= S_DYING;
                        r_idx       <= IMG_DEATH;
                        r_death_cnt <= '0;
                    end else if (bus.airborne_in) begin
                        r_state <= S_JUMP;
                        r_idx   <= IMG_JUMP;
                    end else if (bus.moving_in) begin
                        if (r_state != S_WALK) begin
                            r_state    <= S_WALK;
                            r_idx      <= IMG_WALK0;
                            r_step_cnt <= '0;
                        end else if (r_step_cnt == STEP_LAST) begin
                            r_step_cnt <= '0;
                            r_idx      <= next_walk_img(r_idx);
                        end else begin
                            r_step_cnt <= r_step_cnt + 6'd1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_idx   <= IMG_STAND;
                    end
                end
            endcase
        end else begin
            if (bus.collision_in) begin
                r_col_pend <= 1'b1;
            end
            if (bus.respawn_in) begin
                r_res_pend <= 1'b1;
            end
        end
    end

    assign bus.unique_image_index = r_idx;
    assign bus.flip_h_out         = r_flip;
    assign bus.dead_out           = r_dead;
    assign bus.frame_tick_out     = w_frame_tick;

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sprite_anim_sequencer
// Two sequencers share one stimulus stream: instance 0 with the default
// timing (6 frames per walk step, 30-frame death hold) and instance 1 with
// both set to 1. Every cycle both are compared with a frame-level reference
// model; directed tables and sequences add fixed expected values.
// -----------------------------------------------------------------------------
module tb_sprite_anim_sequencer;

    localparam int TICK_H = 0;
    localparam int TICK_V = 240;
    localparam int FPS [2] = '{6, 1};
    localparam int DH  [2] = '{30, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        moving, airborne, facing, collision, respawn;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sprite_anim_sequencer_if if0 ();
    sprite_anim_sequencer_if if1 ();

    assign if0.hcount_in = hcount;      assign if1.hcount_in = hcount;
    assign if0.vcount_in = vcount;      assign if1.vcount_in = vcount;
    assign if0.moving_in = moving;      assign if1.moving_in = moving;
    assign if0.airborne_in = airborne;  assign if1.airborne_in = airborne;
    assign if0.facing_left_in = facing; assign if1.facing_left_in = facing;
    assign if0.collision_in = collision; assign if1.collision_in = collision;
    assign if0.respawn_in = respawn;    assign if1.respawn_in = respawn;

    sprite_anim_sequencer #(
        .FRAMES_PER_STEP(6), .DEATH_HOLD(30), .TICK_H(TICK_H), .TICK_V(TICK_V)
    ) dut0 (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(if0)
    );

    sprite_anim_sequencer #(
        .FRAMES_PER_STEP(1), .DEATH_HOLD(1), .TICK_H(TICK_H), .TICK_V(TICK_V)
    ) dut1 (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .bus(if1)
    );

    // Frame-level reference model: walking image derived from the number of
    // frames spent walking, death from the number of frames spent dying.
    bit m_dying [2], m_dead [2], m_walk [2], m_col [2], m_res [2];
    bit m_flip [2], m_tick [2];
    int m_idx [2], walk_t [2], death_t [2];

    task automatic model_step(input int k, input logic [10:0] h, input logic [9:0] v);
        bit t, col, res;
        if (!rst_n) begin
            m_dying[k] = 0; m_dead[k] = 0; m_walk[k] = 0; m_col[k] = 0;
            m_res[k] = 0; m_flip[k] = 0; m_tick[k] = 0; m_idx[k] = 0;
            walk_t[k] = 0; death_t[k] = 0;
            return;
        end
        t   = (h == TICK_H) && (v == TICK_V);
        col = m_col[k] | collision;
        res = m_res[k] | respawn;
        m_tick[k] = t;
        if (!t) begin
            m_col[k] = col;
            m_res[k] = res;
            return;
        end
        m_col[k] = 0;
        m_res[k] = 0;
        if (m_dead[k]) begin
            if (res) begin
                m_dead[k] = 0;
                m_idx[k]  = 0;
            end
        end else if (m_dying[k]) begin
            death_t[k]++;
            if (death_t[k] == DH[k]) begin
                m_dying[k] = 0;
                m_dead[k]  = 1;
            end
        end else begin
            m_flip[k] = facing;
            if (col) begin
                m_dying[k] = 1; death_t[k] = 0; m_idx[k] = 5; m_walk[k] = 0;
            end else if (airborne) begin
                m_idx[k] = 4; m_walk[k] = 0;
            end else if (moving) begin
                if (!m_walk[k]) begin
                    m_walk[k] = 1;
                    walk_t[k] = 0;
                end else begin
                    walk_t[k]++;
                end
                m_idx[k] = 1 + (walk_t[k] / FPS[k]) % 3;
            end else begin
                m_idx[k] = 0; m_walk[k] = 0;
            end
        end
    endtask

    function automatic int model_word(input int k);
        return (m_idx[k] << 3) | (int'(m_flip[k]) << 2) | (int'(m_dead[k]) << 1) | int'(m_tick[k]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given raster position; model and both DUTs advance
    // on the same edge and are compared 1 time unit later.
    task automatic cyc(input logic [10:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        model_step(0, h, v);
        model_step(1, h, v);
        @(posedge clk);
        #1;
        chk("inst0_cycle", int'({if0.unique_image_index, if0.flip_h_out, if0.dead_out, if0.frame_tick_out}), model_word(0));
        chk("inst1_cycle", int'({if1.unique_image_index, if1.flip_h_out, if1.dead_out, if1.frame_tick_out}), model_word(1));
    endtask

    // n_pre non-tick cycles followed by the tick cycle (index n_pre).
    // Pulses / reset are applied in the cycle with the given index (-1: none).
    task automatic frame(input int n_pre, input int col_at, input int res_at, input int rst_at);
        logic [10:0] h;
        logic [9:0]  v;
        for (int c = 0; c <= n_pre; c++) begin
            if (c == n_pre) begin
                h = 11'(TICK_H); v = 10'(TICK_V);
            end else if ($urandom_range(0, 3) == 0) begin
                h = 11'(TICK_H); v = 10'(TICK_V - 1);
            end else if ($urandom_range(0, 3) == 0) begin
                h = 11'(TICK_H + 1); v = 10'(TICK_V);
            end else begin
                h = 11'($urandom_range(1, 1500)); v = 10'($urandom_range(0, 1023));
            end
            collision = (c == col_at);
            respawn   = (c == res_at);
            rst_n     = (c != rst_at);
            cyc(h, v);
        end
        collision = 0;
        respawn   = 0;
        rst_n     = 1;
    endtask

    function automatic int out3(input int k);
        if (k == 0) return int'({if0.unique_image_index, if0.flip_h_out, if0.dead_out});
        return int'({if1.unique_image_index, if1.flip_h_out, if1.dead_out});
    endfunction

    typedef struct {
        bit mv, air, face, col, res;
        int idx;
        bit flip, dead;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int exp_idx;
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 0, 0, 1, 0};
        tbl[2] = '{1, 0, 1, 0, 0, 1, 1, 0};
        tbl[3] = '{1, 1, 0, 0, 0, 4, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 1, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 0, 0, 4, 1, 0};
        tbl[8] = '{0, 1, 0, 1, 0, 5, 0, 0};
        tbl[9] = '{1, 0, 1, 0, 1, 5, 0, 0};

        rst_n = 0; hcount = 0; vcount = 0;
        moving = 1; airborne = 0; facing = 1; collision = 0; respawn = 0;

        // Reset held for 3 clocks, one of them on a tick position.
        cyc(11'd5, 10'd5);
        cyc(11'(TICK_H), 10'(TICK_V));
        cyc(11'd7, 10'd7);
        chk("reset_outputs", int'({if0.unique_image_index, if0.flip_h_out, if0.dead_out, if0.frame_tick_out}), 0);
        rst_n = 1;
        cyc(11'd3, 10'd3);
        chk("idx_before_first_tick", int'(if0.unique_image_index), 0);

        for (int i = 0; i < 10; i++) begin
            moving = tbl[i].mv; airborne = tbl[i].air; facing = tbl[i].face;
            frame(2, tbl[i].col ? 1 : -1, tbl[i].res ? 1 : -1, -1);
            chk($sformatf("table_row%0d", i), out3(0), (tbl[i].idx << 2) | (int'(tbl[i].flip) << 1) | int'(tbl[i].dead));
        end

        // Walk cadence from a clean start.
        rst_n = 0; cyc(11'd1, 10'd1); rst_n = 1;
        moving = 1; airborne = 0; facing = 0;
        for (int t = 1; t <= 19; t++) begin
            frame(2, -1, -1, -1);
            exp_idx = (t <= 6) ? 1 : (t <= 12) ? 2 : (t <= 18) ? 3 : 1;
            chk($sformatf("walk_tick%0d", t), int'(if0.unique_image_index), exp_idx);
            chk($sformatf("walk_fps1_tick%0d", t), int'(if1.unique_image_index), ((t - 1) % 3) + 1);
        end

        // Death: flip frozen, respawn while dying discarded, dead after 30 ticks.
        facing = 1;
        frame(2, -1, -1, -1);
        frame(3, 1, -1, -1);
        chk("death_enter", out3(0), (5 << 2) | 2);
        for (int n = 1; n <= 30; n++) begin
            facing = n[0];
            frame(2, -1, (n == 10) ? 0 : -1, -1);
            chk($sformatf("dying_tick%0d", n), out3(0), (5 << 2) | 2 | ((n == 30) ? 1 : 0));
        end

        // Respawn pulse on the tick cycle itself.
        frame(2, -1, 2, -1);
        chk("respawn", out3(0), 2);
        facing = 0;
        frame(1, -1, -1, -1);
        chk("walk_after_respawn", out3(0), 1 << 2);

        // Reset in the middle of dying restarts the death count.
        moving = 0;
        frame(2, 2, -1, -1);
        chk("death_on_tick_pulse", int'(if0.unique_image_index), 5);
        for (int n = 1; n <= 10; n++) frame(1, -1, -1, -1);
        rst_n = 0; cyc(11'd9, 10'd9); rst_n = 1;
        chk("reset_mid_dying", int'({if0.unique_image_index, if0.flip_h_out, if0.dead_out, if0.frame_tick_out}), 0);
        frame(2, 1, -1, -1);
        chk("death_after_reset", int'(if0.unique_image_index), 5);
        for (int n = 1; n <= 30; n++) begin
            frame(1, -1, -1, -1);
            chk($sformatf("redeath_tick%0d_dead", n), int'(if0.dead_out), (n == 30) ? 1 : 0);
        end

        // Randomized frames against the model.
        for (int f = 0; f < 400; f++) begin
            int n_pre;
            n_pre    = $urandom_range(0, 3);
            moving   = ($urandom_range(0, 3) != 0);
            airborne = ($urandom_range(0, 4) == 0);
            facing   = $urandom_range(0, 1) != 0;
            frame(n_pre,
                  ($urandom_range(0, 11) == 0) ? $urandom_range(0, n_pre) : -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, n_pre) : -1,
                  ($urandom_range(0, 59) == 0) ? $urandom_range(0, n_pre) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
